// File: rtl/alu_rf_sequencer.sv
// Single-operation ALU sequencer sharing a 1R/1W register file with a host port.
// Define ALU_RF_SEQ_MUL_EN to enable op 0xA (MUL); otherwise 0xA is illegal.
module alu_rf_sequencer #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src_a,
  input  logic [AW-1:0] cmd_src_b,
  output logic          done,
  output logic          err,
  output logic [3:0]    flags,
  input  logic          host_we,
  input  logic [AW-1:0] host_wAddr,
  input  logic [DW-1:0] host_wData,
  input  logic [AW-1:0] host_rAddr,
  output logic [DW-1:0] host_rData,
  output logic          host_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_wAddr,
  output logic [DW-1:0] rf_wData,
  output logic [AW-1:0] rf_rAddr,
  input  logic [DW-1:0] rf_rData
);

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d, src_a_q, src_a_d, src_b_q, src_b_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [3:0]    exec_flags_q, exec_flags_d, flags_q, flags_d;
  logic          illegal_q, illegal_d;

  logic [DW:0]   alu_sum, alu_diff;
  logic [DW-1:0] alu_res;
  logic          alu_c, alu_v, alu_illegal;

  // Carry/borrow come from the extra top bit of the widened add/subtract.
  always_comb begin
    alu_sum     = {1'b0, opa_q} + {1'b0, opb_q};
    alu_diff    = {1'b0, opa_q} - {1'b0, opb_q};
    alu_res     = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_illegal = 1'b0;
    case (op_q)
      4'h0: alu_res = opa_q;
      4'h1: begin
        alu_res = alu_sum[DW-1:0];
        alu_c   = alu_sum[DW];
        alu_v   = (opa_q[DW-1] == opb_q[DW-1]) && (alu_res[DW-1] != opa_q[DW-1]);
      end
      4'h2: begin
        alu_res = alu_diff[DW-1:0];
        alu_c   = ~alu_diff[DW];
        alu_v   = (opa_q[DW-1] != opb_q[DW-1]) && (alu_res[DW-1] != opa_q[DW-1]);
      end
      4'h3: alu_res = opa_q & opb_q;
      4'h4: alu_res = opa_q | opb_q;
      4'h5: alu_res = opa_q ^ opb_q;
      4'h6: alu_res = ~opa_q;
      4'h7: alu_res = opa_q << opb_q[4:0];
      4'h8: alu_res = opa_q >> opb_q[4:0];
      4'h9: alu_res = DW'($signed(opa_q) >>> opb_q[4:0]);
`ifdef ALU_RF_SEQ_MUL_EN
      4'hA: alu_res = opa_q * opb_q;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dst_d        = dst_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    exec_flags_d = exec_flags_q;
    flags_d      = flags_q;
    illegal_d    = illegal_q;
    cmd_ready    = 1'b0;
    host_ready   = 1'b0;
    host_rData   = '0;
    rf_we        = 1'b0;
    rf_wAddr     = '0;
    rf_wData     = '0;
    rf_rAddr     = '0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Host owns both register-file ports while idle.
        cmd_ready  = 1'b1;
        host_ready = 1'b1;
        rf_rAddr   = host_rAddr;
        host_rData = rf_rData;
        rf_we      = host_we;
        rf_wAddr   = host_wAddr;
        rf_wData   = host_wData;
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          src_a_d = cmd_src_a;
          src_b_d = cmd_src_b;
          state_d = S_RDA;
        end
      end
      S_RDA: begin
        rf_rAddr = src_a_q;
        opa_d    = rf_rData;
        state_d  = S_RDB;
      end
      S_RDB: begin
        rf_rAddr = src_b_q;
        opb_d    = rf_rData;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        result_d     = alu_res;
        exec_flags_d = {alu_res[DW-1], (alu_res == '0), alu_c, alu_v};
        illegal_d    = alu_illegal;
        state_d      = S_WB;
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wAddr = dst_q;
        rf_wData = result_q;
        done     = 1'b1;
        err      = illegal_q;
        flags_d  = exec_flags_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flags = flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      dst_q        <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      exec_flags_q <= '0;
      flags_q      <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dst_q        <= dst_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      result_q     <= result_d;
      exec_flags_q <= exec_flags_d;
      flags_q      <= flags_d;
      illegal_q    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Directed testbench for alu_rf_sequencer with a behavioural 16x32 register file.
// Vector table covers every op code; hand-written sequences cover busy, hazard and reset cases.
module tb_alu_rf_sequencer;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_dst, cmd_src_a, cmd_src_b;
  logic          done, err;
  logic [3:0]    flags;
  logic          host_we;
  logic [AW-1:0] host_wAddr, host_rAddr;
  logic [DW-1:0] host_wData, host_rData;
  logic          host_ready;
  logic          rf_we;
  logic [AW-1:0] rf_wAddr, rf_rAddr;
  logic [DW-1:0] rf_wData, rf_rData;

  always #5 clk = ~clk;

  alu_rf_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .done(done), .err(err), .flags(flags),
    .host_we(host_we), .host_wAddr(host_wAddr), .host_wData(host_wData),
    .host_rAddr(host_rAddr), .host_rData(host_rData), .host_ready(host_ready),
    .rf_we(rf_we), .rf_wAddr(rf_wAddr), .rf_wData(rf_wData),
    .rf_rAddr(rf_rAddr), .rf_rData(rf_rData)
  );

  // Register file: synchronous write, combinational read.
  logic [DW-1:0] mem [16];
  logic          mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (rf_we) begin
      mem[rf_wAddr] <= rf_wData;
    end
  end
  assign rf_rData = mem[rf_rAddr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    host_we = 1'b1; host_wAddr = addr; host_wData = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    host_rAddr = addr;
    #1 data = host_rData;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [3:0] dst,
                          input logic [3:0] sa, input logic [3:0] sb);
    @(negedge clk);
    cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb; cmd_valid = 1'b1;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // lat = 0 means done never arrived within the budget.
  task automatic wait_done(output int lat, output logic e, output logic [31:0] wd,
                           output logic [3:0] wa);
    lat = 0; e = 1'b0; wd = '0; wa = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; e = err; wd = rf_wData; wa = rf_wAddr;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    logic [3:0]  flags;   // {N,Z,C,V}
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        e;
    logic [31:0] wd, rd;
    logic [3:0]  wa;
    int          d1, d2, seen;

    vecs[0]  = '{4'h1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 4'b0000};
    vecs[1]  = '{4'h2, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 4'b1000};
    vecs[2]  = '{4'h1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 4'b1001};
    vecs[3]  = '{4'h9, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 4'b1000};
    vecs[4]  = '{4'h7, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 4'b1000};
    vecs[5]  = '{4'h2, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 4'b0010};
    vecs[6]  = '{4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 4'b0110};
    vecs[7]  = '{4'h3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 4'b0000};
    vecs[8]  = '{4'h4, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 4'b0000};
    vecs[9]  = '{4'h5, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 4'b0000};
    vecs[10] = '{4'h6, 32'h0000_0000, 32'h0000_0055, 32'hFFFF_FFFF, 1'b0, 4'b1000};
    vecs[11] = '{4'h0, 32'h0000_0000, 32'h0000_0077, 32'h0000_0000, 1'b0, 4'b0100};
    vecs[12] = '{4'h8, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 4'b0000};
    vecs[13] = '{4'hF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 4'b0100};
`ifdef ALU_RF_SEQ_MUL_EN
    vecs[14] = '{4'hA, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 4'b0000};
`else
    vecs[14] = '{4'hA, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 1'b1, 4'b0100};
`endif
    vecs[15] = '{4'h2, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 4'b0011};

    reset = 1'b1; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
    host_we = 1'b0; host_wAddr = '0; host_wData = '0; host_rAddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
    check("rst_host_ready", {31'd0, host_ready}, 32'd1);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_err",        {31'd0, err},        32'd0);
    check("rst_flags",      {28'd0, flags},      32'd0);
    check("rst_rf_we",      {31'd0, rf_we},      32'd0);
    check("rst_rf_wAddr",   {28'd0, rf_wAddr},   32'd0);
    check("rst_rf_wData",   rf_wData,            32'd0);
    check("rst_rf_rAddr",   {28'd0, rf_rAddr},   32'd0);
    check("rst_host_rData", host_rData,          32'd0);
    reset = 1'b0; mem_clr = 1'b0;

    for (int i = 0; i < NV; i++) begin
      host_write(4'd1, vecs[i].a);
      host_write(4'd2, vecs[i].b);
      send_cmd(vecs[i].op, 4'd3, 4'd1, 4'd2);
      wait_done(lat, e, wd, wa);
      check("vec_latency", lat, 32'd4);
      check("vec_err", {31'd0, e}, {31'd0, vecs[i].err});
      check("vec_wdata", wd, vecs[i].res);
      check("vec_waddr", {28'd0, wa}, 32'd3);
      host_read(4'd3, rd);
      check("vec_readback", rd, vecs[i].res);
      check("vec_flags", {28'd0, flags}, {28'd0, vecs[i].flags});
      $display("vec %0d op=%h a=%08h b=%08h -> r3=%08h flags=%b err=%0b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, rd, flags, e, lat);
    end

    // Busy: cmd_valid held high, host write during EXEC, chained dependency.
    host_write(4'd1, 32'h10);
    host_write(4'd2, 32'h20);
    host_write(4'd9, 32'hCAFE);
    @(negedge clk);
    cmd_op = 4'h1; cmd_dst = 4'd5; cmd_src_a = 4'd1; cmd_src_b = 4'd2; cmd_valid = 1'b1;
    d1 = 0; d2 = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 4) check("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      if (n == 2) check("busy_host_ready", {31'd0, host_ready}, 32'd0);
      if (n == 3) begin
        host_we = 1'b1; host_wAddr = 4'd9; host_wData = 32'hDEAD;
        #1 check("exec_rf_we", {31'd0, rf_we}, 32'd0);
      end
      if (n == 4) begin
        host_we = 1'b0;
        cmd_op = 4'h5; cmd_dst = 4'd6; cmd_src_a = 4'd5; cmd_src_b = 4'd1;
      end
      if (n == 5) check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      if (n == 6) cmd_valid = 1'b0;
      if (done) begin
        if (d1 == 0) d1 = n;
        else if (d2 == 0) d2 = n;
      end
    end
    check("busy_done1_cycle", d1, 32'd4);
    check("busy_done2_cycle", d2, 32'd9);
    host_read(4'd5, rd); check("busy_r5", rd, 32'h30);
    host_read(4'd6, rd); check("chain_r6", rd, 32'h20);
    host_read(4'd9, rd); check("exec_host_we_ignored", rd, 32'hCAFE);
    $display("busy seq: done at %0d and %0d, r6=%08h", d1, d2, rd);

    // Host write on the accept edge, with src == dst.
    host_write(4'd1, 32'd5);
    @(negedge clk);
    host_we = 1'b1; host_wAddr = 4'd1; host_wData = 32'd100;
    cmd_op = 4'h1; cmd_dst = 4'd1; cmd_src_a = 4'd1; cmd_src_b = 4'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 host_we = 1'b0; cmd_valid = 1'b0;
    wait_done(lat, e, wd, wa);
    check("same_edge_latency", lat, 32'd4);
    check("same_edge_wdata", wd, 32'd200);
    host_read(4'd1, rd);
    check("same_edge_r1", rd, 32'd200);
    $display("same-edge seq: r1=%0d", rd);

    // Reset in EXEC discards the command.
    host_write(4'd7, 32'h1234);
    host_write(4'd1, 32'd1);
    host_write(4'd2, 32'd2);
    send_cmd(4'h1, 4'd7, 4'd1, 4'd2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (done || rf_we) seen++;
      if (n == 1) begin
        check("rst_exec_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
      end
    end
    check("rst_exec_no_wb", seen, 32'd0);
    check("rst_exec_flags", {28'd0, flags}, 32'd0);
    host_read(4'd7, rd);
    check("rst_exec_r7", rd, 32'h1234);
    $display("reset-in-exec seq: r7=%08h wb_events=%0d", rd, seen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
